// File: rtl/seg_disp_sched.sv
// Seven-segment view scheduler: debounced next/mode buttons, manual/auto rotate, CPU status override.
// Ports: clk, rst_n, btn_next, btn_mode, ovr_req in; ovr_ack, disp_type[1:0], auto_mode, disp_chg out.
module seg_disp_sched #(
  parameter int DB_CNT  = 1_000_000,
  parameter int ROT_CNT = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_mode,
  input  logic       ovr_req,
  output logic       ovr_ack,
  output logic [1:0] disp_type,
  output logic       auto_mode,
  output logic       disp_chg
);

  localparam int DW = $clog2(DB_CNT);
  localparam int RW = $clog2(ROT_CNT);

  typedef enum logic [1:0] {
    MANUAL   = 2'd0,
    AUTO     = 2'd1,
    OVERRIDE = 2'd2
  } state_t;

  // index 0 = next, 1 = mode
  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    db;
  logic [1:0]    db_d;
  logic [DW-1:0] dcnt [2];
  logic [1:0]    press;

  assign raw   = {btn_mode, btn_next};
  assign press = db & ~db_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 2; i++)
        dcnt[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DB_CNT - 1)) begin
          db[i]   <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        state;
  state_t        sav_state;
  logic [1:0]    sav_type;
  logic [RW-1:0] rot_cnt;
  logic          next_p;
  logic          mode_p;
  logic          tc;
  logic          step;

  assign next_p = press[0];
  assign mode_p = press[1];
  assign tc     = (rot_cnt == RW'(ROT_CNT - 1));
  // a next pulse and a terminal count together advance only once
  assign step   = next_p | ((state == AUTO) & tc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MANUAL;
      sav_state <= MANUAL;
      sav_type  <= 2'b00;
      rot_cnt   <= '0;
      disp_type <= 2'b00;
      auto_mode <= 1'b0;
      ovr_ack   <= 1'b0;
      disp_chg  <= 1'b0;
    end else begin
      disp_chg <= 1'b0;
      unique case (state)
        MANUAL, AUTO: begin
          if (ovr_req) begin
            sav_state <= state;
            sav_type  <= disp_type;
            state     <= OVERRIDE;
            disp_type <= 2'b11;
            ovr_ack   <= 1'b1;
            auto_mode <= 1'b0;
            disp_chg  <= (disp_type != 2'b11);
          end else begin
            if (step) begin
              disp_type <= disp_type + 2'd1;
              disp_chg  <= 1'b1;
            end
            if (state == AUTO)
              rot_cnt <= step ? '0 : rot_cnt + 1'b1;
            if (mode_p) begin
              if (state == MANUAL) begin
                state     <= AUTO;
                auto_mode <= 1'b1;
                rot_cnt   <= '0;
              end else begin
                state     <= MANUAL;
                auto_mode <= 1'b0;
              end
            end
          end
        end
        OVERRIDE: begin
          // pulses are dropped and rot_cnt holds until release
          if (!ovr_req) begin
            state     <= sav_state;
            disp_type <= sav_type;
            ovr_ack   <= 1'b0;
            auto_mode <= (sav_state == AUTO);
            disp_chg  <= (sav_type != 2'b11);
          end
        end
        default: begin
          state     <= MANUAL;
          auto_mode <= 1'b0;
          ovr_ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched against a behavioural view-scheduler model.
// Directed scenarios followed by randomized button/override traffic.
module tb_seg_disp_sched;

  localparam int DB  = 4;
  localparam int ROT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_next;
  logic       btn_mode;
  logic       ovr_req;
  logic       ovr_ack;
  logic [1:0] disp_type;
  logic       auto_mode;
  logic       disp_chg;

  seg_disp_sched #(.DB_CNT(DB), .ROT_CNT(ROT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_next  (btn_next),
    .btn_mode  (btn_mode),
    .ovr_req   (ovr_req),
    .ovr_ack   (ovr_ack),
    .disp_type (disp_type),
    .auto_mode (auto_mode),
    .disp_chg  (disp_chg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_chg    = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // reference model: 0 = manual, 1 = auto, 2 = override
  int m_mode, m_view, m_rot, m_sav_mode, m_sav_view, m_chg;
  int m_db [2];
  int m_run [2];
  int m_pend [2];
  bit hq0 [$];
  bit hq1 [$];

  task automatic model_reset();
    m_mode = 0; m_view = 0; m_rot = 0;
    m_sav_mode = 0; m_sav_view = 0; m_chg = 0;
    for (int b = 0; b < 2; b++) begin
      m_db[b] = 0; m_run[b] = 0; m_pend[b] = 0;
    end
    hq0.delete();
    hq1.delete();
  endtask

  task automatic model_edge();
    int pul [2];
    int s;
    int old;
    int adv;
    for (int b = 0; b < 2; b++) begin
      pul[b] = m_pend[b];
      m_pend[b] = 0;
      // the level seen by the debouncer was sampled two edges ago
      if (b == 0) begin
        s = (hq0.size() >= 2) ? int'(hq0[0]) : 0;
        hq0.push_back(btn_next);
        if (hq0.size() > 2) void'(hq0.pop_front());
      end else begin
        s = (hq1.size() >= 2) ? int'(hq1[0]) : 0;
        hq1.push_back(btn_mode);
        if (hq1.size() > 2) void'(hq1.pop_front());
      end
      if (s != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_db[b] = s;
          m_run[b] = 0;
          if (s == 1) m_pend[b] = 1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    old = m_view;
    adv = 0;
    if (m_mode != 2 && ovr_req) begin
      m_sav_mode = m_mode;
      m_sav_view = m_view;
      m_mode = 2;
      m_view = 3;
    end else if (m_mode == 2) begin
      if (!ovr_req) begin
        m_mode = m_sav_mode;
        m_view = m_sav_view;
      end
    end else begin
      if (pul[0] != 0) adv = 1;
      if (m_mode == 1) begin
        if (pul[0] != 0) m_rot = 0;
        else if (m_rot == ROT - 1) begin
          adv = 1;
          m_rot = 0;
        end else m_rot++;
      end
      m_view = (m_view + adv) % 4;
      if (pul[1] != 0) begin
        if (m_mode == 0) begin
          m_mode = 1;
          m_rot = 0;
        end else m_mode = 0;
      end
    end
    m_chg = (m_view != old) ? 1 : 0;
  endtask

  task automatic cmp_all();
    chk("disp_type", 32'(disp_type), 32'(m_view));
    chk("auto_mode", 32'(auto_mode), 32'(m_mode == 1));
    chk("ovr_ack",   32'(ovr_ack),   32'(m_mode == 2));
    chk("disp_chg",  32'(disp_chg),  32'(m_chg));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    if (disp_chg) n_chg++;
    cmp_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int b);
    if (b == 0) btn_next = 1'b1; else btn_mode = 1'b1;
    steps(10);
    btn_next = 1'b0;
    btn_mode = 1'b0;
    steps(10);
  endtask

  int guard;
  int rn, rm, ro;

  initial begin
    rst_n = 1'b0; btn_next = 1'b0; btn_mode = 1'b0; ovr_req = 1'b0;
    model_reset();
    #1;
    chk("rst_disp", 32'(disp_type), 32'd0);
    chk("rst_ack",  32'(ovr_ack),   32'd0);
    chk("rst_auto", 32'(auto_mode), 32'd0);
    steps(3);
    rst_n = 1'b1;
    steps(5);

    // four long presses walk the views 1,2,3,0
    n_chg = 0;
    for (int k = 0; k < 4; k++) begin
      btn_next = 1'b1;
      steps(20);
      chk("next_view", 32'(disp_type), 32'((k + 1) % 4));
      btn_next = 1'b0;
      steps(20);
    end
    chk("next_pulses", 32'(n_chg), 32'd4);

    // bouncing contact yields nothing
    n_chg = 0;
    for (int i = 0; i < 30; i++) begin
      btn_next = ~btn_next;
      step();
    end
    btn_next = 1'b0;
    steps(10);
    chk("bounce_pulses", 32'(n_chg), 32'd0);
    chk("bounce_view",   32'(disp_type), 32'd0);

    // auto rotate
    btn_mode = 1'b1;
    steps(10);
    btn_mode = 1'b0;
    steps(40);
    chk("auto_on", 32'(auto_mode), 32'd1);

    // override while in auto at view 2
    guard = 0;
    while (!(m_mode == 1 && m_view == 2) && guard < 64) begin
      step();
      guard++;
    end
    chk("reach_auto_v2", 32'(m_mode == 1 && m_view == 2), 32'd1);
    ovr_req = 1'b1;
    btn_next = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ovr_view", 32'(disp_type), 32'd3);
      chk("ovr_held", 32'(ovr_ack), 32'd1);
    end
    ovr_req = 1'b0;
    btn_next = 1'b0;
    step();
    chk("ovr_restore_view", 32'(disp_type), 32'd2);
    chk("ovr_restore_auto", 32'(auto_mode), 32'd1);
    chk("ovr_released", 32'(ovr_ack), 32'd0);
    steps(20);

    // back to manual, reach view 1, then press both together
    press(1);
    chk("manual_again", 32'(auto_mode), 32'd0);
    guard = 0;
    while (m_view != 1 && guard < 8) begin
      press(0);
      guard++;
    end
    chk("reach_v1", 32'(disp_type), 32'd1);
    btn_next = 1'b1;
    btn_mode = 1'b1;
    guard = 0;
    while (m_mode != 1 && guard < 20) begin
      step();
      guard++;
    end
    chk("both_view", 32'(disp_type), 32'd2);
    chk("both_auto", 32'(auto_mode), 32'd1);
    steps(10);
    btn_next = 1'b0;
    btn_mode = 1'b0;
    steps(10);

    // random traffic
    rn = 0; rm = 0; ro = 0;
    for (int i = 0; i < 600; i++) begin
      if (rn == 0) begin
        btn_next = 1'($urandom_range(0, 1));
        rn = $urandom_range(1, 12);
      end
      if (rm == 0) begin
        btn_mode = 1'($urandom_range(0, 1));
        rm = $urandom_range(1, 14);
      end
      if (ro == 0) begin
        ovr_req = ($urandom_range(0, 3) == 0);
        ro = $urandom_range(1, 30);
      end
      rn--; rm--; ro--;
      step();
    end
    btn_next = 1'b0;
    btn_mode = 1'b0;
    ovr_req  = 1'b0;
    steps(15);

    // asynchronous reset in the middle of an override, button held through it
    ovr_req = 1'b1;
    steps(3);
    chk("pre_rst_ack", 32'(ovr_ack), 32'd1);
    btn_next = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_ack",  32'(ovr_ack),   32'd0);
    chk("async_disp", 32'(disp_type), 32'd0);
    chk("async_auto", 32'(auto_mode), 32'd0);
    chk("async_chg",  32'(disp_chg),  32'd0);
    ovr_req = 1'b0;
    steps(3);
    rst_n = 1'b1;
    n_chg = 0;
    steps(20);
    chk("held_thru_rst_pulses", 32'(n_chg), 32'd1);
    chk("held_thru_rst_view",   32'(disp_type), 32'd1);
    btn_next = 1'b0;
    steps(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
